// File: rtl/vga_sram_frame_reader.sv
// vga_sram_frame_reader: reads a visible VGA frame from the SRAM framebuffer over AXI-Lite,
// one word per pixel in raster order, with a single read in flight at a time. Each pixel is
// presented with its column/row on a valid/ready stream toward the VGA output FIFO.
module vga_sram_frame_reader #(
    parameter int unsigned AXI_ADDR_WIDTH = 20,
    parameter int unsigned AXI_DATA_WIDTH = 16,
    parameter int unsigned H_VISIBLE      = 640,
    parameter int unsigned V_VISIBLE      = 480
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      start,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      rd_err,

    output logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    output logic                      s_axi_arvalid,
    input  logic                      s_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
    input  logic [1:0]                s_axi_rresp,
    input  logic                      s_axi_rvalid,
    output logic                      s_axi_rready,

    output logic [AXI_DATA_WIDTH-1:0] m_pix_data,
    output logic [9:0]                m_pix_col,
    output logic [9:0]                m_pix_row,
    output logic                      m_pix_last,
    output logic                      m_pix_valid,
    input  logic                      m_pix_ready
);

    localparam logic [9:0] ColLast = 10'(H_VISIBLE - 1);
    localparam logic [9:0] RowLast = 10'(V_VISIBLE - 1);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StOut} state_e;

    state_e                    state_q;
    logic [9:0]                col_q;
    logic [9:0]                row_q;
    logic [9:0]                next_col;
    logic [9:0]                next_row;
    logic [AXI_ADDR_WIDTH-1:0] next_addr;

    // Raster advance and the word address of the pixel that follows the current one.
    always_comb begin
        next_col = col_q + 10'd1;
        next_row = row_q;
        if (col_q == ColLast) begin
            next_col = '0;
            next_row = row_q + 10'd1;
        end
        // Full 32-bit product, then truncated to the bus address width.
        next_addr = AXI_ADDR_WIDTH'(32'(next_row) * 32'(H_VISIBLE) + 32'(next_col));
    end

    // Frame walk FSM; every bus and stream output is registered here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            col_q         <= '0;
            row_q         <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            rd_err        <= 1'b0;
            s_axi_araddr  <= '0;
            s_axi_arvalid <= 1'b0;
            s_axi_rready  <= 1'b0;
            m_pix_data    <= '0;
            m_pix_col     <= '0;
            m_pix_row     <= '0;
            m_pix_last    <= 1'b0;
            m_pix_valid   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // A start landing on the frame_done cycle is still treated as busy.
                    if (start && !frame_done) begin
                        col_q         <= '0;
                        row_q         <= '0;
                        rd_err        <= 1'b0;
                        busy          <= 1'b1;
                        s_axi_araddr  <= '0;
                        s_axi_arvalid <= 1'b1;
                        state_q       <= StAddr;
                    end
                end
                StAddr: begin
                    if (s_axi_arready) begin
                        s_axi_arvalid <= 1'b0;
                        s_axi_rready  <= 1'b1;
                        state_q       <= StData;
                    end
                end
                StData: begin
                    if (s_axi_rvalid) begin
                        s_axi_rready <= 1'b0;
                        m_pix_data   <= s_axi_rdata;
                        m_pix_col    <= col_q;
                        m_pix_row    <= row_q;
                        m_pix_last   <= (col_q == ColLast) && (row_q == RowLast);
                        // Errored words still flow downstream; only the sticky flag records it.
                        rd_err       <= rd_err | (s_axi_rresp != 2'b00);
                        m_pix_valid  <= 1'b1;
                        state_q      <= StOut;
                    end
                end
                StOut: begin
                    if (m_pix_ready) begin
                        m_pix_valid <= 1'b0;
                        if (m_pix_last) begin
                            m_pix_last <= 1'b0;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            state_q    <= StIdle;
                        end else begin
                            col_q         <= next_col;
                            row_q         <= next_row;
                            s_axi_araddr  <= next_addr;
                            s_axi_arvalid <= 1'b1;
                            state_q       <= StAddr;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
